// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to weight[i]
// accepted beats, early release on request drop, back-to-back re-arbitration.
module wrr_arb #(
    parameter int N        = 8,
    parameter int WW       = 4,
    parameter int INIT_PTR = 0,
    localparam int IDW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            gnt_ready,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]     state_q;
    logic [IDW-1:0] ptr_q;
    logic [WW-1:0]  credit_q;

    logic [WW-1:0]  weight_arr [N];
    logic           accept;
    logic           dropped;
    logic           release_grant;
    logic           arbitrate;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] arb_start;
    logic [N-1:0]   arb_mask;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [WW-1:0]  win_credit;

    // First requester at or after start, wrapping modulo N. Result is {found, index}.
    function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] start);
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] cand;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            cand = IDW'(j);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) weight_arr[i] = weight[i*WW +: WW];
    end

    // NOTE: every signal assigned in this block gets a value before any branch,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        accept        = gnt_valid & gnt_ready;
        dropped       = (state_q == ST_GRANT) & ~req[gnt_id];
        release_grant = (state_q == ST_GRANT) & ((accept & (credit_q == WW'(1))) | dropped);
        arbitrate     = (state_q == ST_IDLE) | release_grant;
        next_ptr      = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
        arb_start     = (state_q == ST_GRANT) ? next_ptr : ptr_q;
        arb_mask      = req;
        if (dropped) arb_mask[gnt_id] = 1'b0;
        {win_found, win_id} = pick(arb_mask, arb_start);
        // A zero weight still grants one beat.
        win_credit    = (weight_arr[win_id] == '0) ? WW'(1) : weight_arr[win_id];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDW'(INIT_PTR);
            credit_q  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else if (arbitrate) begin
            if (release_grant) ptr_q <= next_ptr;
            if (win_found) begin
                state_q   <= ST_GRANT;
                gnt       <= N'(1) << win_id;
                gnt_valid <= 1'b1;
                gnt_id    <= win_id;
                credit_q  <= win_credit;
            end else begin
                state_q   <= ST_IDLE;
                gnt       <= '0;
                gnt_valid <= 1'b0;
                gnt_id    <= '0;
                credit_q  <= '0;
            end
        end else if (accept) begin
            credit_q <= credit_q - WW'(1);
        end
    end

endmodule
